// File: rtl/p_hardisc.sv
// Shared definitions for the hardisc core: load-info record used by the
// load decoder, AHB-Lite transfer/size codes and the load/store bus
// sequencer state encoding.
package p_hardisc;

    // Load information travelling with a load to the decoder.
    // [4] uns, [3] word, [2] half, [1:0] byte offset
    typedef struct packed {
        logic       uns;
        logic       word;
        logic       half;
        logic [1:0] offset;
    } ld_info;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'b00,
        LSU_DATA  = 2'b01,
        LSU_DRAIN = 2'b10
    } lsu_state_e;

endpackage

// File: rtl/lsu_bus_controller.sv
// Load/store bus sequencer between the memory-access stage and an AHB-Lite
// data bus. Drives the address phase combinationally from the request,
// tracks the data phase through wait states and error responses, replicates
// store data onto byte lanes and rejects misaligned accesses without a bus
// transfer.
//
// Optional feature: define LSU_TIMEOUT_EN to bound data-phase wait states
// to TIMEOUT_CYCLES; on expiry the access completes with an error and the
// controller drains the stalled transfer before accepting new ones.
//
// Ports:
//   s_clk_i, s_resetn_i            clock, asynchronous active-low reset
//   s_req_i .. s_wdata_i           request from the MA stage
//   s_gnt_o                        request accepted onto the bus this cycle
//   s_haddr_o .. s_hwdata_o        AHB-Lite master outputs
//   s_hready_i, s_hresp_i, s_hrdata_i  AHB-Lite slave responses
//   s_ld_info_o, s_rdata_o         load info and raw read word for the decoder
//   s_done_o, s_err_o, s_misaligned_o  completion pulses
module lsu_bus_controller
    import p_hardisc::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        s_req_i,
    input  logic        s_we_i,
    input  logic [31:0] s_addr_i,
    input  logic [1:0]  s_size_i,
    input  logic        s_unsigned_i,
    input  logic [31:0] s_wdata_i,
    output logic        s_gnt_o,
    output logic [31:0] s_haddr_o,
    output logic        s_hwrite_o,
    output logic [2:0]  s_hsize_o,
    output logic [1:0]  s_htrans_o,
    output logic [31:0] s_hwdata_o,
    input  logic        s_hready_i,
    input  logic        s_hresp_i,
    input  logic [31:0] s_hrdata_i,
    output ld_info      s_ld_info_o,
    output logic [31:0] s_rdata_o,
    output logic        s_done_o,
    output logic        s_err_o,
    output logic        s_misaligned_o
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 2..255");
    end

    lsu_state_e  state;
    logic        we_q;
    ld_info      info_q;
    logic [31:0] wdata_q;
    logic        mis_pend;

    logic [1:0]  size_eff;
    logic        aligned;
    logic        completing;
    logic        mis_acc;
    logic        timeout_hit;
    logic [31:0] wdata_rep;
    ld_info      info_d;

    // Size 11 is not a legal AHB data-bus size here; handle it as a word.
    assign size_eff = (s_size_i == 2'b11) ? SIZE_WORD : s_size_i;

    always_comb begin
        aligned   = 1'b1;
        wdata_rep = s_wdata_i;
        case (size_eff)
            SIZE_BYTE: wdata_rep = {4{s_wdata_i[7:0]}};
            SIZE_HALF: begin
                aligned   = ~s_addr_i[0];
                wdata_rep = {2{s_wdata_i[15:0]}};
            end
            default:   aligned = (s_addr_i[1:0] == 2'b00);
        endcase
    end

    assign info_d.uns    = s_unsigned_i;
    assign info_d.word   = (size_eff == SIZE_WORD);
    assign info_d.half   = (size_eff == SIZE_HALF);
    assign info_d.offset = s_addr_i[1:0];

    // A data phase finishes (okay or error) whenever hready is high in DATA.
    assign completing = (state == LSU_DATA) && s_hready_i;

    assign s_gnt_o = s_req_i && aligned && s_hready_i && !s_hresp_i
                     && (state != LSU_DRAIN);

    // Misaligned requests never reach the bus; they are taken once no data
    // phase is left outstanding so their error cannot overtake a real access.
    assign mis_acc = s_req_i && !aligned && ((state != LSU_DATA) || completing);

    assign s_htrans_o = s_gnt_o ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign s_haddr_o  = s_gnt_o ? s_addr_i : 32'h0;
    assign s_hwrite_o = s_gnt_o && s_we_i;
    assign s_hsize_o  = s_gnt_o ? {1'b0, size_eff} : 3'b000;

    assign s_hwdata_o  = (state == LSU_DATA) ? wdata_q : 32'h0;
    assign s_ld_info_o = (state == LSU_DATA) ? info_q : '0;
    assign s_rdata_o   = (completing && !we_q) ? s_hrdata_i : 32'h0;

    assign s_done_o       = completing || mis_pend || timeout_hit;
    assign s_err_o        = (completing && s_hresp_i) || mis_pend || timeout_hit;
    assign s_misaligned_o = mis_pend;

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] tmo_cnt;

    // Fires in the wait cycle after TIMEOUT_CYCLES wait cycles have elapsed.
    assign timeout_hit = (state == LSU_DATA) && !s_hready_i && (tmo_cnt == TMO_LIMIT);

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            tmo_cnt <= 8'h00;
        end else if (s_done_o) begin
            tmo_cnt <= 8'h00;
        end else if ((state == LSU_DATA) && !s_hready_i) begin
            tmo_cnt <= tmo_cnt + 8'h01;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state    <= LSU_IDLE;
            we_q     <= 1'b0;
            info_q   <= '0;
            wdata_q  <= 32'h0;
            mis_pend <= 1'b0;
        end else begin
            mis_pend <= mis_acc;
            if (s_gnt_o) begin
                we_q    <= s_we_i;
                info_q  <= info_d;
                wdata_q <= s_we_i ? wdata_rep : 32'h0;
            end
            case (state)
                LSU_IDLE: begin
                    if (s_gnt_o) state <= LSU_DATA;
                end
                LSU_DATA: begin
                    if (timeout_hit)     state <= LSU_DRAIN;
                    else if (completing) state <= s_gnt_o ? LSU_DATA : LSU_IDLE;
                end
                LSU_DRAIN: begin
                    // Let the stalled slave finish before reusing the bus.
                    if (s_hready_i) state <= LSU_IDLE;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_controller.sv
// Testbench for lsu_bus_controller: table of per-cycle vectors covering
// loads, stores, back-to-back accesses, misalignment and bus errors, plus
// sequences for reset during a data phase and for the wait-state timeout
// (LSU_TIMEOUT_EN) or unbounded waits (default build).
module tb_lsu_bus_controller;
    import p_hardisc::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, uns;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    logic        gnt;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        hready, hresp;
    logic [31:0] hrdata;
    ld_info      info;
    logic [31:0] rdata;
    logic        done, err, mis;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu_bus_controller #(.TIMEOUT_CYCLES(4)) dut (
        .s_clk_i        (clk),
        .s_resetn_i     (rst_n),
        .s_req_i        (req),
        .s_we_i         (we),
        .s_addr_i       (addr),
        .s_size_i       (size),
        .s_unsigned_i   (uns),
        .s_wdata_i      (wdata),
        .s_gnt_o        (gnt),
        .s_haddr_o      (haddr),
        .s_hwrite_o     (hwrite),
        .s_hsize_o      (hsize),
        .s_htrans_o     (htrans),
        .s_hwdata_o     (hwdata),
        .s_hready_i     (hready),
        .s_hresp_i      (hresp),
        .s_hrdata_i     (hrdata),
        .s_ld_info_o    (info),
        .s_rdata_o      (rdata),
        .s_done_o       (done),
        .s_err_o        (err),
        .s_misaligned_o (mis)
    );

    // {gnt, htrans, haddr, hwrite, hsize, hwdata, done, err, mis, rdata, ld_info}
    logic [110:0] outs;
    assign outs = {gnt, htrans, haddr, hwrite, hsize, hwdata, done, err, mis, rdata, info};

    typedef struct {
        string        name;
        logic         req;
        logic         we;
        logic [31:0]  addr;
        logic [1:0]   size;
        logic         uns;
        logic [31:0]  wdata;
        logic         hready;
        logic         hresp;
        logic [31:0]  hrdata;
        logic [110:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [110:0] ex(logic g, logic [1:0] ht, logic [31:0] ha, logic hw,
                                        logic [2:0] hs, logic [31:0] hwd, logic d, logic e,
                                        logic m, logic [31:0] rd, logic [4:0] li);
        return {g, ht, ha, hw, hs, hwd, d, e, m, rd, li};
    endfunction

    function automatic vec_t mk(string n, logic rq, logic w, logic [31:0] a, logic [1:0] s,
                                logic u, logic [31:0] wd, logic hr, logic hp,
                                logic [31:0] hd, logic [110:0] e);
        vec_t v;
        v.name = n; v.req = rq; v.we = w; v.addr = a; v.size = s; v.uns = u;
        v.wdata = wd; v.hready = hr; v.hresp = hp; v.hrdata = hd; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [110:0] got, input logic [110:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: outputs got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input logic rq, input logic w, input logic [31:0] a, input logic [1:0] s,
                        input logic u, input logic [31:0] wd, input logic hr, input logic hp,
                        input logic [31:0] hd);
        @(posedge clk);
        #1;
        req = rq; we = w; addr = a; size = s; uns = u; wdata = wd;
        hready = hr; hresp = hp; hrdata = hd;
        @(negedge clk);
    endtask

    localparam logic [110:0] ZERO = '0;
    localparam logic [110:0] LDW  = 111'b01000;   // only ld_info = word load, offset 0

    initial begin
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; addr = 32'h0; size = 2'b00; uns = 1'b0; wdata = 32'h0;
        hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;

        // load word, zero wait
        vecs.push_back(mk("ldw_addr", 1,0,32'h100,2'b10,0,32'h0, 1,0,32'h0,
            ex(1,2'b10,32'h100,0,3'b010,32'h0, 0,0,0,32'h0,5'b00000)));
        vecs.push_back(mk("ldw_done", 0,0,32'h0,2'b00,0,32'h0, 1,0,32'hDEADBEEF,
            ex(0,2'b00,32'h0,0,3'b000,32'h0, 1,0,0,32'hDEADBEEF,5'b01000)));
        // store byte with two wait states
        vecs.push_back(mk("stb_addr", 1,1,32'h203,2'b00,0,32'h000000A5, 1,0,32'h0,
            ex(1,2'b10,32'h203,1,3'b000,32'h0, 0,0,0,32'h0,5'b00000)));
        vecs.push_back(mk("stb_wait1", 0,0,32'h0,2'b00,0,32'h0, 0,0,32'h0,
            ex(0,2'b00,32'h0,0,3'b000,32'hA5A5A5A5, 0,0,0,32'h0,5'b00011)));
        vecs.push_back(mk("stb_wait2", 0,0,32'h0,2'b00,0,32'h0, 0,0,32'h0,
            ex(0,2'b00,32'h0,0,3'b000,32'hA5A5A5A5, 0,0,0,32'h0,5'b00011)));
        vecs.push_back(mk("stb_done", 0,0,32'h0,2'b00,0,32'h0, 1,0,32'h0,
            ex(0,2'b00,32'h0,0,3'b000,32'hA5A5A5A5, 1,0,0,32'h0,5'b00011)));
        // back-to-back halfword loads
        vecs.push_back(mk("b2b_a0", 1,0,32'h2,2'b01,0,32'h0, 1,0,32'h0,
            ex(1,2'b10,32'h2,0,3'b001,32'h0, 0,0,0,32'h0,5'b00000)));
        vecs.push_back(mk("b2b_d0_a1", 1,0,32'h6,2'b01,1,32'h0, 1,0,32'h12345678,
            ex(1,2'b10,32'h6,0,3'b001,32'h0, 1,0,0,32'h12345678,5'b00110)));
        vecs.push_back(mk("b2b_d1", 0,0,32'h0,2'b00,0,32'h0, 1,0,32'h9ABCDEF0,
            ex(0,2'b00,32'h0,0,3'b000,32'h0, 1,0,0,32'h9ABCDEF0,5'b10110)));
        // misaligned halfword
        vecs.push_back(mk("mis_req", 1,0,32'h1,2'b01,0,32'h0, 1,0,32'h0, ZERO));
        vecs.push_back(mk("mis_done", 0,0,32'h0,2'b00,0,32'h0, 1,0,32'h0,
            ex(0,2'b00,32'h0,0,3'b000,32'h0, 1,1,1,32'h0,5'b00000)));
        vecs.push_back(mk("mis_pulse_end", 0,0,32'h0,2'b00,0,32'h0, 1,0,32'h0, ZERO));
        // two-cycle error response
        vecs.push_back(mk("err_addr", 1,0,32'h40,2'b10,0,32'h0, 1,0,32'h0,
            ex(1,2'b10,32'h40,0,3'b010,32'h0, 0,0,0,32'h0,5'b00000)));
        vecs.push_back(mk("err_first", 1,0,32'h44,2'b10,0,32'h0, 0,1,32'h0, LDW));
        vecs.push_back(mk("err_second", 1,0,32'h44,2'b10,0,32'h0, 1,1,32'h0,
            ex(0,2'b00,32'h0,0,3'b000,32'h0, 1,1,0,32'h0,5'b01000)));
        vecs.push_back(mk("err_next_addr", 1,0,32'h44,2'b10,0,32'h0, 1,0,32'h0,
            ex(1,2'b10,32'h44,0,3'b010,32'h0, 0,0,0,32'h0,5'b00000)));
        vecs.push_back(mk("err_next_done", 0,0,32'h0,2'b00,0,32'h0, 1,0,32'h55AA55AA,
            ex(0,2'b00,32'h0,0,3'b000,32'h0, 1,0,0,32'h55AA55AA,5'b01000)));
        // size 11 handled as word store; misaligned taken as it completes
        vecs.push_back(mk("sz3_addr", 1,1,32'h10,2'b11,0,32'h11223344, 1,0,32'h0,
            ex(1,2'b10,32'h10,1,3'b010,32'h0, 0,0,0,32'h0,5'b00000)));
        vecs.push_back(mk("sz3_done_mis", 1,0,32'h102,2'b10,0,32'h0, 1,0,32'h0,
            ex(0,2'b00,32'h0,0,3'b000,32'h11223344, 1,0,0,32'h0,5'b01000)));
        vecs.push_back(mk("mis2_done", 0,0,32'h0,2'b00,0,32'h0, 1,0,32'h0,
            ex(0,2'b00,32'h0,0,3'b000,32'h0, 1,1,1,32'h0,5'b00000)));
        // misaligned request while a data phase is stalled is not taken
        vecs.push_back(mk("hold_addr", 1,0,32'h0,2'b10,0,32'h0, 1,0,32'h0,
            ex(1,2'b10,32'h0,0,3'b010,32'h0, 0,0,0,32'h0,5'b00000)));
        vecs.push_back(mk("hold_mis_wait", 1,0,32'h3,2'b01,0,32'h0, 0,0,32'h0, LDW));
        vecs.push_back(mk("hold_done", 0,0,32'h0,2'b00,0,32'h0, 1,0,32'hCAFEF00D,
            ex(0,2'b00,32'h0,0,3'b000,32'h0, 1,0,0,32'hCAFEF00D,5'b01000)));
        vecs.push_back(mk("hold_idle", 0,0,32'h0,2'b00,0,32'h0, 1,0,32'h0, ZERO));

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", outs, ZERO);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns,
                 vecs[i].wdata, vecs[i].hready, vecs[i].hresp, vecs[i].hrdata);
            check(vecs[i].name, outs, vecs[i].exp);
        end

        // reset asserted in the middle of a data phase
        step(1, 0, 32'h300, 2'b10, 0, 32'h0, 1, 0, 32'h0);
        check("rst_mid_addr", outs, ex(1,2'b10,32'h300,0,3'b010,32'h0, 0,0,0,32'h0,5'b00000));
        step(0, 0, 32'h0, 2'b00, 0, 32'h0, 0, 0, 32'h0);
        check("rst_mid_wait", outs, LDW);
        #1;
        hready = 1'b1; hrdata = 32'hFFFFFFFF;
        rst_n = 1'b0;
        #1;
        check("rst_mid_async", outs, ZERO);
        @(posedge clk);
        #1;
        check("rst_mid_held", outs, ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 32'h0, 2'b00, 0, 32'h0, 1, 0, 32'hFFFFFFFF);
        check("rst_mid_no_done", outs, ZERO);

`ifdef LSU_TIMEOUT_EN
        // TIMEOUT_CYCLES = 4: error in the fifth stalled cycle, then drain
        step(1, 0, 32'h80, 2'b10, 0, 32'h0, 1, 0, 32'h0);
        check("tmo_addr", outs, ex(1,2'b10,32'h80,0,3'b010,32'h0, 0,0,0,32'h0,5'b00000));
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 32'h0, 2'b00, 0, 32'h0, 0, 0, 32'h0);
            check($sformatf("tmo_wait%0d", k), outs, LDW);
        end
        step(0, 0, 32'h0, 2'b00, 0, 32'h0, 0, 0, 32'h0);
        check("tmo_hit", outs, ex(0,2'b00,32'h0,0,3'b000,32'h0, 1,1,0,32'h0,5'b01000));
        for (int k = 6; k <= 10; k++) begin
            step(1, 0, 32'h84, 2'b10, 0, 32'h0, 0, 0, 32'h0);
            check($sformatf("tmo_drain%0d", k), outs, ZERO);
        end
        step(1, 0, 32'h84, 2'b10, 0, 32'h0, 1, 0, 32'h0);
        check("tmo_drain_exit", outs, ZERO);
        step(1, 0, 32'h84, 2'b10, 0, 32'h0, 1, 0, 32'h0);
        check("tmo_regrant", outs, ex(1,2'b10,32'h84,0,3'b010,32'h0, 0,0,0,32'h0,5'b00000));
        step(0, 0, 32'h0, 2'b00, 0, 32'h0, 1, 0, 32'h0BADC0DE);
        check("tmo_regrant_done", outs, ex(0,2'b00,32'h0,0,3'b000,32'h0, 1,0,0,32'h0BADC0DE,5'b01000));
`else
        // without the timeout, a long stall simply waits
        step(1, 0, 32'h80, 2'b10, 0, 32'h0, 1, 0, 32'h0);
        check("long_addr", outs, ex(1,2'b10,32'h80,0,3'b010,32'h0, 0,0,0,32'h0,5'b00000));
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, 32'h0, 2'b00, 0, 32'h0, 0, 0, 32'h0);
            check($sformatf("long_wait%0d", k), outs, LDW);
        end
        step(0, 0, 32'h0, 2'b00, 0, 32'h0, 1, 0, 32'h0BADC0DE);
        check("long_done", outs, ex(0,2'b00,32'h0,0,3'b000,32'h0, 1,0,0,32'h0BADC0DE,5'b01000));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_bus_controller.md
# lsu_bus_controller

Load/store bus sequencer between the memory-access pipeline stage and the AHB-Lite data bus. Accepts one load/store request at a time and drives the AHB address phase. Tracks the pipelined data phase through wait states and error responses, and presents the raw read word plus the matching `ld_info` to the load decoder when the data phase completes. Also replicates store data onto byte lanes and rejects misaligned accesses without touching the bus.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64, maximum data-phase wait cycles before abort (only with `LSU_TIMEOUT_EN`); legal range 2..255

Ports:
- `s_clk_i`  in  1  clock
- `s_resetn_i`  in  1  reset, asynchronous, active-low
- `s_req_i`  in  1  access request from the MA stage
- `s_we_i`  in  1  1 = store, 0 = load
- `s_addr_i`  in  32  byte address
- `s_size_i`  in  2  00 byte, 01 halfword, 10 word; 11 is illegal and treated as word
- `s_unsigned_i`  in  1  zero-extend load
- `s_wdata_i`  in  32  store data, right-aligned
- `s_gnt_o`  out  1  request accepted this cycle
- `s_haddr_o`  out  32  AHB address
- `s_hwrite_o`  out  1  AHB write
- `s_hsize_o`  out  3  AHB size = {1'b0, s_size_i}
- `s_htrans_o`  out  2  00 IDLE, 10 NONSEQ
- `s_hwdata_o`  out  32  AHB write data (data phase)
- `s_hready_i`  in  1  AHB ready
- `s_hresp_i`  in  1  AHB error response
- `s_hrdata_i`  in  32  AHB read data
- `s_ld_info_o`  out  `ld_info`  load info of the completing load, for the decoder
- `s_rdata_o`  out  32  raw read word (= `s_hrdata_i` when `s_done_o` is set for a load)
- `s_done_o`  out  1  access completed (load or store, success or error)
- `s_err_o`  out  1  completion is a bus error, misalignment or timeout
- `s_misaligned_o`  out  1  completion is a misalignment rejection

## Operation
FSM states:
- **IDLE**: no data phase in flight.
- **DATA**: a data phase is in flight.
- **DRAIN**: timeout build only; ignore bus until `s_hready_i`=1.

Address phase:
- Address-phase outputs are combinational from the request. When `s_gnt_o`=1: `s_htrans_o`=10, and `s_haddr_o`, `s_hwrite_o` and `s_hsize_o` follow the inputs. Otherwise `s_htrans_o`=00 and the other address-phase outputs are 0.
- `s_gnt_o` = `s_req_i` & aligned & `s_hready_i` & ~`s_hresp_i` & (state≠DRAIN).
- Alignment: halfword needs `addr[0]`=0; word needs `addr[1:0]`=00.
- Misaligned request (`s_req_i`=1 & misaligned):
  - No bus transfer; it is acknowledged through a dedicated grant path.
  - That path requires state≠DATA, or DATA completing this cycle.
  - The following cycle pulses `s_done_o`, `s_err_o` and `s_misaligned_o` together.

On grant, register for the data phase:
- We flag.
- `ld_info`: [1:0] = `addr[1:0]`, [2] = half, [3] = word, [4] = unsigned.
- Replicated store data: byte → {4{b}}, half → {2{h}}, word unchanged.
- Move to DATA.

In DATA:
- `s_hready_i`=1 & ~`s_hresp_i`: `s_done_o`=1 and `s_rdata_o`=`s_hrdata_i`. Go to IDLE, or stay in DATA if a new grant happens in the same cycle (back-to-back pipelining).
- Error: `s_hresp_i`=1 & `s_hready_i`=0 is the first error cycle; no grant is given. `s_hresp_i`=1 & `s_hready_i`=1 gives `s_done_o`=1 and `s_err_o`=1, then IDLE.
- `s_hwdata_o` holds the registered store data for the whole data phase; it is 0 otherwise.
- `s_ld_info_o` is valid whenever state=DATA; the decoder uses it when `s_done_o` is set.

## Timing
- Reset: state IDLE, all registers 0, every output 0 (`s_htrans_o`=00).
- Reset asserted mid-data phase discards the transfer; no `s_done_o` is issued.
- Latency from grant to `s_done_o` = 1 + bus wait cycles. Back-to-back sustains one access per cycle.
- `s_done_o`, `s_err_o` and `s_misaligned_o` are single-cycle pulses.
- `s_rdata_o` is combinational from `s_hrdata_i`.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - An 8-bit counter counts DATA cycles with `s_hready_i`=0.
  - On reaching `TIMEOUT_CYCLES`: pulse `s_done_o` and `s_err_o`, then go to DRAIN.
  - DRAIN grants nothing and returns to IDLE on `s_hready_i`=1.
  - The counter clears on every completion.
- `LSU_TIMEOUT_EN` undefined: no counter, no DRAIN state; wait states are unbounded.

## Structure
- `p_hardisc` already holds the `ld_info` typedef, and this block uses it.
- The following constants are added to `p_hardisc`:
  - HTRANS codes (IDLE=00, NONSEQ=10).
  - Size codes (byte 00, half 01, word 10).
  - FSM state enum.
- No sub-module; the timeout counter is inline under `` `ifdef``.

## Test plan
- Load word, `addr` 0x100, zero wait: grant cycle 0; `s_done_o` cycle 1 with `s_rdata_o`=`s_hrdata_i`=0xDEADBEEF and `ld_info`=01000.
- Store byte 0xA5 at 0x203 with 2 wait states: `s_hsize_o`=000, `s_hwdata_o`=0xA5A5A5A5 held 3 cycles; `s_done_o` cycle 3.
- Back-to-back halfword loads at 0x2 and 0x6 (unsigned): two grants in consecutive cycles; `done` in cycles 1 and 2 with `ld_info` 00110 then 10110.
- Load half at 0x1: `htrans` stays 00; next cycle `s_done_o`, `s_err_o` and `s_misaligned_o` are all 1.
- Bus error, two-cycle hresp: no grant in the first error cycle; `s_err_o`=1 with `s_done_o` in the second cycle.
- Timeout build, `TIMEOUT_CYCLES`=4, `hready` low for 10 cycles: `s_err_o` after 4 wait cycles; no grant until `hready`=1; reset mid-DATA gives all outputs 0 and no `done`.
